// File: rtl/mem_loader_if.sv
// Byte-stream, memory-write, memory-read and result-stream signals shared
// between mem_loader (master) and its environment (slave).
interface mem_loader_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic [7:0]       inData;
    logic             inLast;

    logic             memEn;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memData;

    logic [WIDTH-1:0] rdAddr;
    logic [7:0]       rdData;

    logic             outValid;
    logic             outReady;
    logic [7:0]       outData;
    logic             outLast;

    modport master (
        input  inValid, inData, inLast, rdData, outReady,
        output inReady, memEn, memAddr, memData, rdAddr, outValid, outData, outLast
    );

    modport slave (
        output inValid, inData, inLast, rdData, outReady,
        input  inReady, memEn, memAddr, memData, rdAddr, outValid, outData, outLast
    );
endinterface

// File: rtl/mem_loader.sv
// Loads a byte stream into processor memory, holds the core in reset, runs it
// until it halts (or the watchdog fires), then streams the result bytes out.
module mem_loader #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] DIN_ADDR       = 'h3E00,
    parameter logic [WIDTH-1:0] DOUT_ADDR      = 'h3F00,
    parameter int               MAX_IO_SIZE    = 256,
    parameter logic [WIDTH-1:0] HALT_PC        = 'h14,
    parameter int               MAX_RUN_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset,
    mem_loader_if.master     bus,
    output logic             cpuReset,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] a0,
    output logic             done,
    output logic             timeout,
    output logic [WIDTH-1:0] retCode
);
    localparam int CNT_W = $clog2(MAX_IO_SIZE + 1);
    localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);

    typedef enum logic [2:0] {LOAD, CPU_RST, RUN, ISSUE, CAPTURE, DONE} state_t;
    state_t state, next;

    logic [CNT_W-1:0] byteCnt;
    logic [CNT_W-1:0] rdIdx;
    logic [CNT_W-1:0] outCnt;
    logic [CNT_W-1:0] haltCnt;
    logic [RUN_W-1:0] runCnt;
    logic             rstPhase;
    logic             loadReady;
    logic             inFire;
    logic             outFire;
    logic             halt;
    logic             expired;

    assign loadReady   = (state == LOAD) && (byteCnt < CNT_W'(MAX_IO_SIZE));
    assign bus.inReady = loadReady;
    assign inFire      = bus.inValid && loadReady;
    assign outFire     = bus.outValid && bus.outReady;
    assign halt        = (pc == HALT_PC);
    assign expired     = (runCnt == RUN_W'(MAX_RUN_CYCLES - 1));

    // Result length: a0 words of 4 bytes, clamped to [0, MAX_IO_SIZE]
    always_comb begin
        haltCnt = '0;
        if ($signed(a0) <= 0)
            haltCnt = '0;
        else if ($signed(a0) > $signed(WIDTH'(MAX_IO_SIZE / 4)))
            haltCnt = CNT_W'(MAX_IO_SIZE);
        else
            haltCnt = CNT_W'(a0 << 2);
    end

    always_comb begin
        next       = state;
        cpuReset   = 1'b0;
        bus.rdAddr = '0;
        case (state)
            LOAD: begin
                if (inFire && (bus.inLast || byteCnt == CNT_W'(MAX_IO_SIZE - 1)))
                    next = CPU_RST;
            end
            CPU_RST: begin
                cpuReset = 1'b1;
                if (rstPhase)
                    next = RUN;
            end
            RUN: begin
                if (halt)
                    next = (haltCnt != '0) ? ISSUE : DONE;
                else if (expired)
                    next = DONE;
            end
            ISSUE: begin
                bus.rdAddr = DOUT_ADDR + WIDTH'(rdIdx);
                next       = CAPTURE;
            end
            CAPTURE: begin
                if (outFire)
                    next = bus.outLast ? DONE : ISSUE;
            end
            DONE:    next = DONE;
            default: next = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            byteCnt      <= '0;
            rdIdx        <= '0;
            outCnt       <= '0;
            runCnt       <= '0;
            rstPhase     <= 1'b0;
            bus.memEn    <= 1'b0;
            bus.memAddr  <= '0;
            bus.memData  <= '0;
            bus.outValid <= 1'b0;
            bus.outLast  <= 1'b0;
            bus.outData  <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            retCode      <= '0;
        end else begin
            state       <= next;
            done        <= (next == DONE);
            bus.memEn   <= inFire;
            bus.memAddr <= inFire ? DIN_ADDR + WIDTH'(byteCnt) : '0;
            bus.memData <= inFire ? WIDTH'(bus.inData) : '0;
            if (inFire)
                byteCnt <= byteCnt + CNT_W'(1);

            // rstPhase marks the second cpuReset cycle
            rstPhase <= (state == CPU_RST) && !rstPhase;
            runCnt   <= (state == RUN) ? runCnt + RUN_W'(1) : '0;

            if (state == RUN) begin
                if (halt) begin
                    retCode <= a0;
                    outCnt  <= haltCnt;
                end else if (expired) begin
                    retCode <= '0;
                    timeout <= 1'b1;
                end
            end

            // First CAPTURE cycle registers the read data; then hold until accepted
            if (state == CAPTURE) begin
                if (!bus.outValid) begin
                    bus.outValid <= 1'b1;
                    bus.outData  <= bus.rdData;
                    bus.outLast  <= (rdIdx == outCnt - CNT_W'(1));
                end else if (bus.outReady) begin
                    bus.outValid <= 1'b0;
                    bus.outLast  <= 1'b0;
                    rdIdx        <= rdIdx + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// Randomised scoreboard bench for mem_loader: a reference model queues the
// expected memory writes and output bytes, a monitor compares what appears.
module tb_mem_loader;
    localparam int          WIDTH  = 32;
    localparam int          MAXIO  = 256;
    localparam int          MAXRUN = 300;
    localparam logic [31:0] DIN    = 32'h3E00;
    localparam logic [31:0] DOUT   = 32'h3F00;
    localparam logic [31:0] HALT   = 32'h14;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpuReset;
    logic        done;
    logic        timeout;
    logic [31:0] pc = '0;
    logic [31:0] a0 = '0;
    logic [31:0] retCode;

    mem_loader_if #(.WIDTH(WIDTH)) bus ();

    mem_loader #(
        .WIDTH(WIDTH),
        .DIN_ADDR(DIN),
        .DOUT_ADDR(DOUT),
        .MAX_IO_SIZE(MAXIO),
        .HALT_PC(HALT),
        .MAX_RUN_CYCLES(MAXRUN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .cpuReset(cpuReset),
        .pc(pc),
        .a0(a0),
        .done(done),
        .timeout(timeout),
        .retCode(retCode)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] wq [$];
    logic [8:0]  oq [$];
    logic [7:0]  dout_img [0:MAXIO-1];
    int          model_cnt = 0;
    bit          model_loading = 1'b1;
    int          n_out = 0;
    int          hold_at = -1;
    int          hold_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_count(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s <= 0) return 0;
        if (s * 4 > MAXIO) return MAXIO;
        return int'(s * 4);
    endfunction

    // Synchronous read memory holding the result region
    always @(posedge clock) begin
        if (bus.rdAddr >= DOUT && bus.rdAddr < DOUT + 32'(MAXIO))
            bus.rdData <= dout_img[8'(bus.rdAddr - DOUT)];
        else
            bus.rdData <= 8'hEE;
    end

    // Consumer: random back-pressure plus an optional 5-cycle stall at byte hold_at
    always @(posedge clock) begin
        #1;
        if (hold_cnt > 0) begin
            bus.outReady = 1'b0;
            hold_cnt--;
        end else if (hold_at >= 0 && n_out == hold_at && bus.outValid) begin
            bus.outReady = 1'b0;
            hold_cnt = 4;
            hold_at = -1;
        end else begin
            bus.outReady = ($urandom_range(0, 3) != 0);
        end
    end

    int          cr_len = 0;
    logic        stalled = 1'b0;
    logic [8:0]  held = '0;
    logic [63:0] w_exp;
    logic [8:0]  o_exp;

    always @(negedge clock) begin
        if (!reset) begin
            cr_len  = 0;
            stalled = 1'b0;
        end else begin
            if (bus.memEn) begin
                check("write_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    w_exp = wq.pop_front();
                    check("mem_write", {bus.memAddr, bus.memData}, w_exp);
                end
            end else begin
                check("mem_idle", {bus.memAddr, bus.memData}, 64'd0);
            end
            if (cpuReset) cr_len++;
            else if (cr_len != 0) begin
                check("cpuReset_cycles", 64'(cr_len), 64'd2);
                cr_len = 0;
            end
            if (stalled)
                check("out_hold", 64'({bus.outValid, bus.outLast, bus.outData}), 64'({1'b1, held}));
            if (bus.outValid && bus.outReady) begin
                check("out_expected", 64'(oq.size() != 0), 64'd1);
                if (oq.size() != 0) begin
                    o_exp = oq.pop_front();
                    check("out_byte", 64'({bus.outLast, bus.outData}), 64'(o_exp));
                end
                n_out++;
            end
            stalled = bus.outValid && !bus.outReady;
            held    = {bus.outLast, bus.outData};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.inValid = 1'b0;
        bus.inData  = 8'h00;
        bus.inLast  = 1'b0;
        pc          = '0;
        a0          = '0;
        repeat (2) tick();
        wq.delete();
        oq.delete();
        model_cnt     = 0;
        model_loading = 1'b1;
        n_out         = 0;
        hold_at       = -1;
        reset         = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAXIO; i++) dout_img[i] = 8'($urandom);
    endtask

    task automatic check_idle_outputs();
        check("rst_mem", {bus.memAddr, bus.memData}, 64'd0);
        check("rst_flags", 64'({bus.memEn, cpuReset, bus.outValid, bus.outLast, done, timeout}), 64'd0);
        check("rst_outData", 64'(bus.outData), 64'd0);
        check("rst_rdAddr", 64'(bus.rdAddr), 64'd0);
        check("rst_retCode", 64'(retCode), 64'd0);
    endtask

    task automatic load_stream(input int n, input bit use_last);
        bit rdy;
        for (int i = 0; i < n; i++) begin
            if (model_loading) repeat ($urandom_range(0, 2)) tick();
            bus.inValid = 1'b1;
            bus.inData  = 8'($urandom);
            bus.inLast  = use_last && (i == n - 1);
            @(negedge clock);
            rdy = model_loading && (model_cnt < MAXIO);
            check("inReady", 64'(bus.inReady), 64'(rdy));
            if (rdy) begin
                wq.push_back({DIN + 32'(model_cnt), 24'd0, bus.inData});
                model_cnt++;
                if (bus.inLast || model_cnt == MAXIO) model_loading = 1'b0;
            end
            tick();
            bus.inValid = 1'b0;
            bus.inLast  = 1'b0;
            if (!rdy) break;
        end
    endtask

    // Returns at the falling edge of the first RUN cycle
    task automatic wait_run();
        int k = 0;
        while (!cpuReset && k < 20) begin @(negedge clock); k++; end
        while (cpuReset && k < 20) begin @(negedge clock); k++; end
        check("reach_run", 64'(k < 20), 64'd1);
    endtask

    task automatic halt_with(input logic [31:0] v, input int dly);
        int cnt;
        for (int i = 0; i < dly; i++) begin
            tick();
            pc = 32'($urandom_range(32'h20, 32'h200));
        end
        tick();
        pc  = HALT;
        a0  = v;
        cnt = exp_count(v);
        for (int i = 0; i < cnt; i++) oq.push_back({(i == cnt - 1), dout_img[i]});
        tick();
        pc = 32'h0;
        a0 = 32'($urandom);
    endtask

    task automatic finish_check(input logic [31:0] v);
        int k = 0;
        while (!done && k < 5000) begin @(negedge clock); k++; end
        check("done_reached", 64'(done), 64'd1);
        repeat (3) @(negedge clock);
        check("done_sticky", 64'(done), 64'd1);
        check("timeout_clear", 64'(timeout), 64'd0);
        check("retCode", 64'(retCode), 64'(v));
        check("out_count", 64'(n_out), 64'(exp_count(v)));
        check("out_queue_empty", 64'(oq.size()), 64'd0);
        check("write_queue_empty", 64'(wq.size()), 64'd0);
        check("inReady_done", 64'(bus.inReady), 64'd0);
    endtask

    task automatic run_program(input int n, input bit use_last, input logic [31:0] v, input int hold);
        do_reset();
        hold_at = hold;
        load_stream(n, use_last);
        wait_run();
        halt_with(v, int'($urandom_range(1, 8)));
        finish_check(v);
    endtask

    task automatic reset_now();
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs();
        do_reset();
        @(negedge clock);
        check("inReady_after_reset", 64'(bus.inReady), 64'd1);
    endtask

    initial begin
        int k;
        bus.outReady = 1'b0;
        do_reset();
        @(negedge clock);
        check_idle_outputs();
        check("inReady_reset", 64'(bus.inReady), 64'd1);

        for (int i = 0; i < MAXIO; i++) dout_img[i] = 8'(i + 1);
        run_program(8, 1'b1, 32'd3, 4);
        fill_random(); run_program(300, 1'b0, 32'd100, -1);
        fill_random(); run_program(5, 1'b1, 32'hFFFF_FFFF, -1);
        fill_random(); run_program(2, 1'b1, 32'd0, -1);
        fill_random(); run_program(6, 1'b1, 32'd64, -1);
        fill_random(); run_program(3, 1'b1, 32'd65, 10);
        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_program(int'($urandom_range(1, 20)), 1'b1,
                        32'(int'($urandom_range(0, 70)) - 3), -1);
        end

        // Watchdog expiry
        do_reset();
        a0 = 32'd5;
        load_stream(4, 1'b1);
        wait_run();
        k = 0;
        while (!done && k < MAXRUN + 50) begin @(negedge clock); k++; end
        check("timeout_cycles", 64'(k), 64'(MAXRUN));
        check("timeout_flag", 64'(timeout), 64'd1);
        check("timeout_done", 64'(done), 64'd1);
        check("timeout_retCode", 64'(retCode), 64'd0);

        // Reset in the middle of a drain
        do_reset();
        fill_random();
        load_stream(3, 1'b1);
        wait_run();
        halt_with(32'd10, 2);
        k = 0;
        while (n_out < 3 && k < 500) begin @(negedge clock); k++; end
        check("drain_started", 64'(k < 500), 64'd1);
        reset_now();

        // Reset while the processor is running
        load_stream(2, 1'b1);
        wait_run();
        repeat (3) tick();
        reset_now();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL sim_time_limit: got no finish, expected finish before 3 ms");
        $fatal(1, "simulation time limit");
    end
endmodule
